// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between fetch (F) and debug (D); 1-cycle read latency.
// No back-pressure on responses. Optional D anti-starvation via IMEM_ARB_FAIR_EN.
module imem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_kill,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-4:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_F_RD = 2'd1,
        OWN_D_RD = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_first;

    // Byte offset within the 8-byte word plays no part in the memory access.
    logic unused_byte_off;
    assign unused_byte_off = ^{f_addr[2:0], d_addr[2:0]};

`ifdef IMEM_ARB_FAIR_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign d_first = (wait_q == WAIT_W'(MAX_WAIT));

    always_comb begin
        wait_d = wait_q;
        if (!d_req || d_gnt) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign d_first = 1'b0;
`endif

    // F wins by default; D only when F is idle, being redirected, or D has waited too long.
    always_comb begin
        f_gnt = rst && f_req && !f_kill && !(d_first && d_req);
        d_gnt = rst && d_req && (!f_req || f_kill || d_first);
    end

    always_comb begin
        mem_addr = '0;
        if (d_gnt) begin
            mem_addr = d_addr[ADDR_W-1:3];
        end else if (f_gnt) begin
            mem_addr = f_addr[ADDR_W-1:3];
        end
    end

    always_comb begin
        owner_d = OWN_IDLE;
        if (f_gnt) begin
            owner_d = OWN_F_RD;
        end else if (d_gnt) begin
            owner_d = OWN_D_RD;
        end
    end

    // A redirect in the response cycle squashes the wrong-path fetch word.
    always_comb begin
        f_rvalid  = (owner_q == OWN_F_RD) && !f_kill;
        d_rvalid  = (owner_q == OWN_D_RD);
        f_rdata_d = f_rvalid ? mem_dout : f_rdata_q;
        d_rdata_d = d_rvalid ? mem_dout : d_rdata_q;
        f_rdata   = f_rdata_d;
        d_rdata   = d_rdata_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OWN_IDLE;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            owner_q   <= owner_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a registered-read memory model.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_kill, d_req;
    logic [31:0] f_addr, d_addr;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid;
    logic [63:0] f_rdata, d_rdata, mem_dout;
    logic [28:0] mem_addr;

    int n_vec = 0;
    int n_err = 0;
    int first_d, n_d;
    logic f_after;

    imem_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wv(input int idx);
        return 64'hC0DE_0000_0000_0000 | (64'(idx) * 64'h0101);
    endfunction

    always @(posedge clk) mem_dout <= wv(int'(mem_addr[5:0]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; f_req = 1'b1; f_addr = 32'h0; f_kill = 1'b0;
        d_req = 1'b0; d_addr = 32'h0;
        repeat (2) step;
        #2;
        chk("rst_f_gnt", 64'(f_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_f_rvalid", 64'(f_rvalid), 64'd0);
        chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        chk("rst_f_rdata", f_rdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);

        step; rst = 1'b1; #2;
        chk("rel_f_gnt", 64'(f_gnt), 64'd1);
        chk("s0_mem_addr", 64'(mem_addr), 64'd0);
        step; f_addr = 32'h08; #2;
        chk("s1_mem_addr", 64'(mem_addr), 64'd1);
        chk("s0_rvalid", 64'(f_rvalid), 64'd1);
        chk("s0_rdata", f_rdata, wv(0));
        step; f_addr = 32'h10; #2;
        chk("s2_mem_addr", 64'(mem_addr), 64'd2);
        chk("s1_rdata", f_rdata, wv(1));
        step; f_req = 1'b0; #2;
        chk("s_idle_gnt", 64'(f_gnt), 64'd0);
        chk("s2_rvalid", 64'(f_rvalid), 64'd1);
        chk("s2_rdata", f_rdata, wv(2));
        step; #2;
        chk("s_end_rvalid", 64'(f_rvalid), 64'd0);
        chk("s_hold_rdata", f_rdata, wv(2));

        step; f_req = 1'b1; f_addr = 32'h40; #2;
        chk("k_gnt", 64'(f_gnt), 64'd1);
        chk("k_mem_addr", 64'(mem_addr), 64'd8);
        step; f_kill = 1'b1; #2;
        chk("k_kill_gnt", 64'(f_gnt), 64'd0);
        chk("k_kill_rvalid", 64'(f_rvalid), 64'd0);
        chk("k_kill_rdata", f_rdata, wv(2));
        step; f_kill = 1'b0; f_addr = 32'h80; #2;
        chk("k_refetch_gnt", 64'(f_gnt), 64'd1);
        chk("k_refetch_addr", 64'(mem_addr), 64'd16);
        chk("k_refetch_norv", 64'(f_rvalid), 64'd0);
        step; f_req = 1'b0; #2;
        chk("k_rvalid", 64'(f_rvalid), 64'd1);
        chk("k_rdata", f_rdata, wv(16));

        step; d_req = 1'b1; d_addr = 32'h18; #2;
        chk("c_d_gnt", 64'(d_gnt), 64'd1);
        chk("c_f_gnt", 64'(f_gnt), 64'd0);
        chk("c_mem_addr", 64'(mem_addr), 64'd3);
        step; d_addr = 32'h28; f_req = 1'b1; f_addr = 32'h20; #2;
        chk("c_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("c_d_rdata", d_rdata, wv(3));
        chk("c_both_f_gnt", 64'(f_gnt), 64'd1);
        chk("c_both_d_gnt", 64'(d_gnt), 64'd0);
        chk("c_both_addr", 64'(mem_addr), 64'd4);
        step; f_kill = 1'b1; #2;
        chk("c_kill_d_gnt", 64'(d_gnt), 64'd1);
        chk("c_kill_f_gnt", 64'(f_gnt), 64'd0);
        chk("c_kill_addr", 64'(mem_addr), 64'd5);
        chk("c_kill_f_rv", 64'(f_rvalid), 64'd0);
        step; f_kill = 1'b0; d_req = 1'b0; #2;
        chk("c_d_rvalid2", 64'(d_rvalid), 64'd1);
        chk("c_d_rdata2", d_rdata, wv(5));
        chk("c_f_gnt2", 64'(f_gnt), 64'd1);

        step; d_req = 1'b1; d_addr = 32'h38;
        first_d = 0; n_d = 0; f_after = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            #2;
            if (d_gnt) begin
                n_d++;
                if (first_d == 0) first_d = i;
            end
            if (first_d != 0 && i == first_d + 1) f_after = f_gnt;
            step;
        end
`ifdef IMEM_ARB_FAIR_EN
        chk("fair_first_d", 64'(first_d), 64'd9);
        chk("fair_n_d", 64'(n_d), 64'd1);
        chk("fair_f_resume", 64'(f_after), 64'd1);
`else
        chk("strict_n_d", 64'(n_d), 64'd0);
`endif

        d_req = 1'b0; f_addr = 32'h30; #2;
        chk("r_gnt", 64'(f_gnt), 64'd1);
        #1 rst = 1'b0; #1;
        chk("r_async_gnt", 64'(f_gnt), 64'd0);
        chk("r_async_addr", 64'(mem_addr), 64'd0);
        chk("r_async_rdata", f_rdata, 64'd0);
        step; #2;
        chk("r_lost_rvalid", 64'(f_rvalid), 64'd0);
        step; rst = 1'b1; f_req = 1'b0; #2;
        chk("r_idle_f_rv", 64'(f_rvalid), 64'd0);
        chk("r_idle_d_rv", 64'(d_rvalid), 64'd0);
        step; f_req = 1'b1; f_addr = 32'h08; #2;
        chk("r_post_gnt", 64'(f_gnt), 64'd1);
        step; f_req = 1'b0; #2;
        chk("r_post_rvalid", 64'(f_rvalid), 64'd1);
        chk("r_post_rdata", f_rdata, wv(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
